// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - Connect-four turn sequencing: move validation, turn timer, auto-placement, win/draw handling.
module turn_controller #(
    parameter int TURN_CYCLES = 500000000,
    parameter int MAX_MOVES   = 42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_req,
    input  logic [2:0]  move_col,
    input  logic        col_full,
    input  logic        check_done,
    input  logic        check_win,
    output logic        insert_en,
    output logic [1:0]  player_id,
    output logic [2:0]  col_sel,
    output logic        check_start,
    output logic        move_reject,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [5:0]  move_count,
    output logic [28:0] time_left
);

    localparam logic [28:0] TL_INIT    = 29'(TURN_CYCLES - 1);
    localparam logic [5:0]  MOVE_LIMIT = 6'(MAX_MOVES);

    typedef enum logic [2:0] {
        IDLE, WAIT_MOVE, CHECK_COL, INSERT, CHECK_WAIT, SWITCH, AUTO_SCAN, OVER
    } state_t;

    state_t state, state_nxt;
    logic   scan_phase;
    logic   load_game, take_move, reject, timeout, scan_next, set_win, set_draw;

    assign insert_en = (state == INSERT);
    assign game_over = (state == OVER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_game = 1'b0;
        take_move = 1'b0;
        reject    = 1'b0;
        timeout   = 1'b0;
        scan_next = 1'b0;
        set_win   = 1'b0;
        set_draw  = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    load_game = 1'b1;
                    state_nxt = WAIT_MOVE;
                end
            end
            WAIT_MOVE: begin
                // A request arriving on the last timer cycle still beats the timeout.
                if (move_req) begin
                    if (move_col <= 3'd6) begin
                        take_move = 1'b1;
                        state_nxt = CHECK_COL;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (time_left == 29'd0) begin
                    timeout   = 1'b1;
                    state_nxt = AUTO_SCAN;
                end
            end
            CHECK_COL: begin
                if (col_full) begin
                    reject    = 1'b1;
                    state_nxt = WAIT_MOVE;
                end else begin
                    state_nxt = INSERT;
                end
            end
            INSERT: state_nxt = CHECK_WAIT;
            CHECK_WAIT: begin
                if (check_done) begin
                    if (check_win) begin
                        set_win   = 1'b1;
                        state_nxt = OVER;
                    end else if (move_count == MOVE_LIMIT) begin
                        set_draw  = 1'b1;
                        state_nxt = OVER;
                    end else begin
                        state_nxt = SWITCH;
                    end
                end
            end
            SWITCH: state_nxt = WAIT_MOVE;
            AUTO_SCAN: begin
                // Phase 0 presents col_sel to the board; phase 1 reads its col_full answer.
                if (scan_phase) begin
                    if (!col_full) begin
                        state_nxt = INSERT;
                    end else if (col_sel == 3'd6) begin
                        set_draw  = 1'b1;
                        state_nxt = OVER;
                    end else begin
                        scan_next = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_id   <= 2'b01;
            col_sel     <= 3'd0;
            move_count  <= 6'd0;
            winner      <= 2'b00;
            time_left   <= TL_INIT;
            check_start <= 1'b0;
            move_reject <= 1'b0;
            scan_phase  <= 1'b0;
        end else begin
            check_start <= (state == INSERT);
            move_reject <= reject;
            if ((state == WAIT_MOVE || state == CHECK_COL) && time_left != 29'd0)
                time_left <= time_left - 29'd1;
            if (take_move)
                col_sel <= move_col;
            if (timeout) begin
                col_sel    <= 3'd0;
                scan_phase <= 1'b0;
            end else if (state == AUTO_SCAN) begin
                scan_phase <= ~scan_phase;
            end
            if (scan_next)
                col_sel <= col_sel + 3'd1;
            if (state == INSERT)
                move_count <= move_count + 6'd1;
            if (set_win)
                winner <= player_id;
            if (set_draw)
                winner <= 2'b00;
            if (state == SWITCH) begin
                player_id <= {player_id[0], player_id[1]};
                time_left <= TL_INIT;
            end
            if (load_game) begin
                player_id  <= 2'b01;
                col_sel    <= 3'd0;
                move_count <= 6'd0;
                winner     <= 2'b00;
                time_left  <= TL_INIT;
            end
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - Self-checking bench for turn_controller with board/win-checker models.
module tb_turn_controller;

    localparam int TC = 20;
    localparam int MM = 42;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        move_req = 1'b0;
    logic [2:0]  move_col = 3'd0;
    logic        col_full;
    logic        check_done = 1'b0;
    logic        check_win = 1'b0;
    logic        insert_en;
    logic [1:0]  player_id;
    logic [2:0]  col_sel;
    logic        check_start;
    logic        move_reject;
    logic        game_over;
    logic [1:0]  winner;
    logic [5:0]  move_count;
    logic [28:0] time_left;

    logic [6:0]  full_mask = 7'd0;
    logic        win_flag = 1'b0;
    logic [4:0]  ins_q[$];
    int          rej_cnt = 0;
    int          viol_cnt = 0;
    logic        prev_ins = 1'b0;
    int          chk_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    turn_controller #(.TURN_CYCLES(TC), .MAX_MOVES(MM)) dut (
        .clk(clk), .rst(rst), .start(start), .move_req(move_req), .move_col(move_col),
        .col_full(col_full), .check_done(check_done), .check_win(check_win),
        .insert_en(insert_en), .player_id(player_id), .col_sel(col_sel),
        .check_start(check_start), .move_reject(move_reject), .game_over(game_over),
        .winner(winner), .move_count(move_count), .time_left(time_left)
    );

    always #5 clk = ~clk;

    assign col_full = full_mask[col_sel];

    // Board-side observer: records every insert and counts reject pulses and illegal inserts.
    always @(negedge clk) begin
        if (!rst) begin
            prev_ins = 1'b0;
        end else begin
            if (insert_en) begin
                ins_q.push_back({player_id, col_sel});
                if (prev_ins || col_full) viol_cnt++;
            end
            if (move_reject) rej_cnt++;
            prev_ins = insert_en;
        end
    end

    // Win checker: answers each check_start after a random 1-3 cycle latency.
    always @(negedge clk) begin
        if (!rst) begin
            chk_cnt    = 0;
            check_done = 1'b0;
            check_win  = 1'b0;
        end else begin
            check_done = 1'b0;
            check_win  = 1'b0;
            if (chk_cnt != 0) begin
                chk_cnt--;
                if (chk_cnt == 0) begin
                    check_done = 1'b1;
                    check_win  = win_flag;
                end
            end
            if (check_start) chk_cnt = $urandom_range(1, 3);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic play(input logic [2:0] c);
        move_col = c;
        move_req = 1'b1;
        cyc(1);
        move_req = 1'b0;
    endtask

    task automatic start_game(input logic [6:0] mask);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        full_mask = mask;
        win_flag = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        ins_q.delete();
        rej_cnt = 0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cyc(2);
        n_checks++; if (insert_en !== 1'b0) begin n_fail++; $display("FAIL reset_insert_en: got %0b want 0", insert_en); end
        n_checks++; if (player_id !== 2'b01) begin n_fail++; $display("FAIL reset_player: got %0b want 01", player_id); end
        n_checks++; if (col_sel !== 3'd0) begin n_fail++; $display("FAIL reset_col_sel: got %0d want 0", col_sel); end
        n_checks++; if ({check_start, move_reject, game_over} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {check_start, move_reject, game_over}); end
        n_checks++; if (winner !== 2'b00 || move_count !== 6'd0) begin n_fail++; $display("FAIL reset_winner_count: got %0b/%0d want 00/0", winner, move_count); end
        n_checks++; if (time_left !== 29'(TC - 1)) begin n_fail++; $display("FAIL reset_time_left: got %0d want %0d", time_left, TC - 1); end
        rst = 1'b1;
        cyc(6);
        n_checks++; if (time_left !== 29'(TC - 1) || game_over !== 1'b0 || insert_en !== 1'b0) begin n_fail++; $display("FAIL idle_without_start: time_left %0d game_over %0b", time_left, game_over); end
    endtask

    task automatic test_basic_turn;
        start_game(7'd0);
        n_checks++; if (player_id !== 2'b01 || move_count !== 6'd0 || winner !== 2'b00) begin n_fail++; $display("FAIL start_init: got p=%0b cnt=%0d w=%0b want 01/0/00", player_id, move_count, winner); end
        n_checks++; if (time_left !== 29'(TC - 1)) begin n_fail++; $display("FAIL start_time_left: got %0d want %0d", time_left, TC - 1); end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        n_checks++; if (time_left !== 29'(TC - 2)) begin n_fail++; $display("FAIL start_ignored_mid_turn: time_left %0d want %0d", time_left, TC - 2); end
        play(3'd3);
        cyc(9);
        n_checks++; if (ins_q.size() !== 1) begin n_fail++; $display("FAIL basic_insert_count: got %0d want 1", ins_q.size()); end
        else begin
            n_checks++; if (ins_q[0] !== {2'b01, 3'd3}) begin n_fail++; $display("FAIL basic_insert_value: got %b want 01011", ins_q[0]); end
        end
        n_checks++; if (move_count !== 6'd1) begin n_fail++; $display("FAIL basic_move_count: got %0d want 1", move_count); end
        n_checks++; if (player_id !== 2'b10) begin n_fail++; $display("FAIL basic_switch: got %0b want 10", player_id); end
    endtask

    task automatic test_rejects;
        ins_q.delete();
        rej_cnt = 0;
        full_mask = 7'b0001000;
        play(3'd3);
        cyc(3);
        play(3'd7);
        cyc(3);
        n_checks++; if (rej_cnt !== 2) begin n_fail++; $display("FAIL reject_pulses: got %0d want 2", rej_cnt); end
        n_checks++; if (ins_q.size() !== 0) begin n_fail++; $display("FAIL reject_no_insert: got %0d inserts want 0", ins_q.size()); end
        n_checks++; if (player_id !== 2'b10 || move_count !== 6'd1) begin n_fail++; $display("FAIL reject_state: got p=%0b cnt=%0d want 10/1", player_id, move_count); end
    endtask

    task automatic test_move_beats_timeout;
        start_game(7'd0);
        cyc(TC - 1);
        n_checks++; if (time_left !== 29'd0) begin n_fail++; $display("FAIL timer_reaches_zero: got %0d want 0", time_left); end
        play(3'd5);
        cyc(9);
        n_checks++; if (ins_q.size() !== 1 || ins_q[0] !== {2'b01, 3'd5}) begin n_fail++; $display("FAIL move_vs_timeout: got %0d inserts, first %b want 01101", ins_q.size(), ins_q.size() > 0 ? ins_q[0] : 5'd0); end
    endtask

    task automatic test_timeout_scan;
        start_game(7'b0000011);
        cyc(TC + 20);
        n_checks++; if (ins_q.size() !== 1 || ins_q[0] !== {2'b01, 3'd2}) begin n_fail++; $display("FAIL timeout_autoinsert: got %0d inserts, first %b want 01010", ins_q.size(), ins_q.size() > 0 ? ins_q[0] : 5'd0); end
        n_checks++; if (player_id !== 2'b10 || move_count !== 6'd1) begin n_fail++; $display("FAIL timeout_after: got p=%0b cnt=%0d want 10/1", player_id, move_count); end
    endtask

    task automatic test_timeout_full;
        start_game(7'h7f);
        cyc(TC + 20);
        n_checks++; if (game_over !== 1'b1 || winner !== 2'b00) begin n_fail++; $display("FAIL full_board_over: got over=%0b winner=%0b want 1/00", game_over, winner); end
        n_checks++; if (ins_q.size() !== 0 || move_count !== 6'd0) begin n_fail++; $display("FAIL full_board_no_insert: got %0d inserts cnt %0d want 0/0", ins_q.size(), move_count); end
    endtask

    task automatic test_win;
        logic [1:0] exp_p;
        logic [2:0] c;
        start_game(7'd0);
        exp_p = 2'b01;
        for (int i = 0; i < 7; i++) begin
            win_flag = (i == 6);
            c = 3'($urandom_range(0, 6));
            play(c);
            cyc(9);
            n_checks++; if (ins_q.size() !== 1 || ins_q[0] !== {exp_p, c}) begin n_fail++; $display("FAIL win_move%0d: got %0d inserts, first %b want %b", i, ins_q.size(), ins_q.size() > 0 ? ins_q[0] : 5'd0, {exp_p, c}); end
            ins_q.delete();
            if (i != 6) exp_p = (exp_p == 2'b01) ? 2'b10 : 2'b01;
        end
        n_checks++; if (game_over !== 1'b1 || winner !== 2'b01 || move_count !== 6'd7) begin n_fail++; $display("FAIL win_result: got over=%0b winner=%0b cnt=%0d want 1/01/7", game_over, winner, move_count); end
        rej_cnt = 0;
        play(3'd2);
        cyc(5);
        play(3'd7);
        cyc(5);
        n_checks++; if (ins_q.size() !== 0 || rej_cnt !== 0 || game_over !== 1'b1 || winner !== 2'b01) begin n_fail++; $display("FAIL over_ignores_moves: inserts %0d rejects %0d over %0b", ins_q.size(), rej_cnt, game_over); end
    endtask

    task automatic test_random_turns;
        logic [1:0] exp_p;
        int         exp_cnt, exp_rej, used;
        logic [2:0] c;
        logic [6:0] m;
        start_game(7'd0);
        exp_p = 2'b01;
        exp_cnt = 0;
        exp_rej = 0;
        used = 0;
        for (int i = 0; i < 30; i++) begin
            m = 7'($urandom_range(0, 127));
            c = 3'($urandom_range(0, 7));
            if (used + 4 > 16) begin
                c = 3'($urandom_range(0, 6));
                m[c] = 1'b0;
            end
            full_mask = m;
            if (c > 3'd6 || m[c]) begin
                exp_rej++;
                used += 4;
                play(c);
                cyc(3);
            end else begin
                play(c);
                cyc(9);
                n_checks++; if (ins_q.size() !== 1 || ins_q[0] !== {exp_p, c}) begin n_fail++; $display("FAIL rand_insert%0d: got %0d inserts, first %b want %b", i, ins_q.size(), ins_q.size() > 0 ? ins_q[0] : 5'd0, {exp_p, c}); end
                ins_q.delete();
                exp_cnt++;
                exp_p = (exp_p == 2'b01) ? 2'b10 : 2'b01;
                used = 3;
            end
        end
        n_checks++; if (ins_q.size() !== 0 || rej_cnt !== exp_rej) begin n_fail++; $display("FAIL rand_rejects: got %0d rejects %0d stray inserts want %0d/0", rej_cnt, ins_q.size(), exp_rej); end
        n_checks++; if (player_id !== exp_p || move_count !== 6'(exp_cnt)) begin n_fail++; $display("FAIL rand_state: got p=%0b cnt=%0d want %0b/%0d", player_id, move_count, exp_p, exp_cnt); end
    endtask

    task automatic test_draw;
        logic [1:0] exp_p;
        int         bad;
        logic [2:0] c;
        start_game(7'd0);
        exp_p = 2'b01;
        bad = 0;
        for (int i = 0; i < MM; i++) begin
            c = 3'($urandom_range(0, 6));
            play(c);
            cyc(9);
            if (ins_q.size() != 1 || ins_q[0] !== {exp_p, c}) bad++;
            ins_q.delete();
            if (i != MM - 1) exp_p = (exp_p == 2'b01) ? 2'b10 : 2'b01;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL draw_inserts: got %0d wrong inserts want 0", bad); end
        n_checks++; if (game_over !== 1'b1 || winner !== 2'b00 || move_count !== 6'(MM)) begin n_fail++; $display("FAIL draw_result: got over=%0b winner=%0b cnt=%0d want 1/00/%0d", game_over, winner, move_count, MM); end
        n_checks++; if (player_id !== exp_p) begin n_fail++; $display("FAIL draw_last_player: got %0b want %0b", player_id, exp_p); end
    endtask

    task automatic test_reset_mid_insert;
        logic found;
        start_game(7'd0);
        play(3'd4);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (insert_en) found = 1'b1;
            else cyc(1);
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL reach_insert: insert_en not seen within 10 cycles"); end
        rst = 1'b0;
        #1;
        n_checks++; if (insert_en !== 1'b0 || col_sel !== 3'd0 || player_id !== 2'b01) begin n_fail++; $display("FAIL async_reset: got ins=%0b col=%0d p=%0b want 0/0/01", insert_en, col_sel, player_id); end
        n_checks++; if (time_left !== 29'(TC - 1) || move_count !== 6'd0 || {check_start, move_reject, game_over} !== 3'b000 || winner !== 2'b00) begin n_fail++; $display("FAIL async_reset_rest: tl=%0d cnt=%0d flags=%b w=%0b", time_left, move_count, {check_start, move_reject, game_over}, winner); end
        cyc(3);
        ins_q.delete();
        rst = 1'b1;
        cyc(5);
        n_checks++; if (ins_q.size() !== 0 || time_left !== 29'(TC - 1) || game_over !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: inserts %0d tl %0d over %0b", ins_q.size(), time_left, game_over); end
    endtask

    initial begin
        test_reset();
        test_basic_turn();
        test_rejects();
        test_move_beats_timeout();
        test_timeout_scan();
        test_timeout_full();
        test_win();
        test_random_turns();
        test_draw();
        test_reset_mid_insert();
        n_checks++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL insert_rules: got %0d back-to-back or full-column inserts want 0", viol_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
